// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
//   state_t  - arbiter sequence states (IDLE -> ACCESS -> RESP)
//   req_id_t - requester identity (CORE / HOST)
//   F3_*     - RV32I load/store size and sign codes
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    CORE = 1'b0,
    HOST = 1'b1
  } req_id_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane placement for one access.
// Ports:
//   we         in  - store (1) / load (0)
//   funct3     in  - RV32I size/sign code
//   a          in  - byte offset within the word (addr[1:0])
//   wdata      in  - LSB-justified store data
//   m_rdata    in  - raw memory word
//   be         out - byte enables (0000 on error)
//   lane_wdata out - store data replicated into every lane
//   rdata      out - extended load result (0 for stores and errors)
//   err        out - misaligned access or illegal funct3
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  input  logic [31:0] wdata,
  input  logic [31:0] m_rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] rdata,
  output logic        err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = m_rdata[{a, 3'b000} +: 8];
  assign half_sel = a[1] ? m_rdata[31:16] : m_rdata[15:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    be         = 4'b0000;
    lane_wdata = '0;
    rdata      = '0;
    err        = 1'b0;

    case (funct3)
      F3_B, F3_BU: begin
        err        = we && (funct3 == F3_BU);  // no unsigned store
        be         = 4'b0001 << a;
        lane_wdata = {4{wdata[7:0]}};
        rdata      = (funct3 == F3_BU) ? {24'b0, byte_sel}
                                       : {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H, F3_HU: begin
        err        = a[0] || (we && (funct3 == F3_HU));
        be         = 4'b0011 << {a[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
        rdata      = (funct3 == F3_HU) ? {16'b0, half_sel}
                                       : {{16{half_sel[15]}}, half_sel};
      end
      F3_W: begin
        err        = (a != 2'b00);
        be         = 4'b1111;
        lane_wdata = wdata;
        rdata      = m_rdata;
      end
      default: err = 1'b1;
    endcase

    // Faulting accesses touch no lanes; stores and faults return zero.
    if (err) be = 4'b0000;
    if (err || we) rdata = '0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the core (c_*)
// and a host loader/debug port (h_*). Every transaction runs
// IDLE -> ACCESS -> RESP with round-robin tie breaking.
// Ports:
//   clk, rst                      - clock, async active-low reset
//   c_req/c_we/c_funct3/c_addr/c_wdata - core request (held until c_rvalid)
//   c_gnt/c_rvalid/c_rdata/c_err  - core grant pulse, completion, result
//   h_req/h_we/h_addr/h_wdata     - host word-only request
//   h_gnt/h_rvalid/h_rdata        - host grant pulse, completion, result
//   m_addr/m_we/m_be/m_wdata      - memory word address, strobe, lanes, data
//   m_rdata                       - memory read data, valid one cycle after m_addr
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 c_req,
  input  logic                 c_we,
  input  logic [2:0]           c_funct3,
  input  logic [31:0]          c_addr,
  input  logic [31:0]          c_wdata,
  output logic                 c_gnt,
  output logic                 c_rvalid,
  output logic [31:0]          c_rdata,
  output logic                 c_err,
  input  logic                 h_req,
  input  logic                 h_we,
  input  logic [31:0]          h_addr,
  input  logic [31:0]          h_wdata,
  output logic                 h_gnt,
  output logic                 h_rvalid,
  output logic [31:0]          h_rdata,
  output logic [ADDR_SIZE-3:0] m_addr,
  output logic                 m_we,
  output logic [3:0]           m_be,
  output logic [31:0]          m_wdata,
  input  logic [31:0]          m_rdata
);

  state_t                 state, state_nxt;
  req_id_t                last, win;
  req_id_t                cap_id;
  logic                   cap_we;
  logic [2:0]             cap_f3;
  logic [ADDR_SIZE-1:0]   cap_addr;
  logic [31:0]            cap_wdata;

  logic [3:0]             la_be;
  logic [31:0]            la_wdata;
  logic [31:0]            la_rdata;
  logic                   la_err;

  // Address bits above the memory size wrap; host byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c_addr[31:ADDR_SIZE], h_addr[31:ADDR_SIZE], h_addr[1:0]};

  // Round-robin: on a tie, the port that did not win last time goes.
  always_comb begin
    win = HOST;
    if (c_req && h_req) win = (last == HOST) ? CORE : HOST;
    else if (c_req)     win = CORE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (c_req || h_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winner's payload once, in IDLE; it is never re-sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last      <= HOST;
      cap_id    <= CORE;
      cap_we    <= 1'b0;
      cap_f3    <= F3_B;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (state == IDLE && (c_req || h_req)) begin
      last   <= win;
      cap_id <= win;
      if (win == CORE) begin
        cap_we    <= c_we;
        cap_f3    <= c_funct3;
        cap_addr  <= c_addr[ADDR_SIZE-1:0];
        cap_wdata <= c_wdata;
      end else begin
        cap_we    <= h_we;
        cap_f3    <= F3_W;
        cap_addr  <= {h_addr[ADDR_SIZE-1:2], 2'b00};
        cap_wdata <= h_wdata;
      end
    end
  end

  dmem_lane_align u_lane_align (
    .we         (cap_we),
    .funct3     (cap_f3),
    .a          (cap_addr[1:0]),
    .wdata      (cap_wdata),
    .m_rdata    (m_rdata),
    .be         (la_be),
    .lane_wdata (la_wdata),
    .rdata      (la_rdata),
    .err        (la_err)
  );

  // Memory address comes straight from the capture register.
  assign m_addr = cap_addr[ADDR_SIZE-1:2];

  // Outputs decode from registered state only, so reset clears them
  // asynchronously and nothing depends combinationally on req/addr.
  always_comb begin
    c_gnt    = 1'b0;
    c_rvalid = 1'b0;
    c_rdata  = '0;
    c_err    = 1'b0;
    h_gnt    = 1'b0;
    h_rvalid = 1'b0;
    h_rdata  = '0;
    m_we     = 1'b0;
    m_be     = 4'b0000;
    m_wdata  = '0;
    case (state)
      ACCESS: begin
        c_gnt   = (cap_id == CORE);
        h_gnt   = (cap_id == HOST);
        m_we    = cap_we && !la_err;
        m_be    = la_be;
        m_wdata = la_wdata;
      end
      RESP: begin
        if (cap_id == CORE) begin
          c_rvalid = 1'b1;
          c_rdata  = la_rdata;
          c_err    = la_err;
        end else begin
          h_rvalid = 1'b1;
          h_rdata  = la_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_pkg::*;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic        chk_be;
    logic [3:0]  be;
    logic        chk_wd;
    logic [31:0] wd;
  } acc_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk, rst;
  logic        c_req, c_we;
  logic [2:0]  c_funct3;
  logic [31:0] c_addr, c_wdata;
  logic        c_gnt, c_rvalid, c_err;
  logic [31:0] c_rdata;
  logic        h_req, h_we;
  logic [31:0] h_addr, h_wdata;
  logic        h_gnt, h_rvalid;
  logic [31:0] h_rdata;
  logic [7:0]  m_addr;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_wdata, m_rdata;

  logic [31:0] mem [256];

  int vectors = 0;
  int miscompares = 0;

  req_id_t order_q[$];
  acc_t    c_acc_q[$], h_acc_q[$];
  rsp_t    c_rsp_q[$], h_rsp_q[$];

  dmem_arbiter #(.ADDR_SIZE(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_funct3 (c_funct3),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .c_err    (c_err),
    .h_req    (h_req),
    .h_we     (h_we),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_gnt    (h_gnt),
    .h_rvalid (h_rvalid),
    .h_rdata  (h_rdata),
    .m_addr   (m_addr),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port memory model: byte-lane writes, registered read.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      if (m_we)
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      m_rdata <= mem[m_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic acc_t mk_acc(input logic [7:0] a, input logic we, input logic cb,
                                  input logic [3:0] be, input logic cw, input logic [31:0] wd);
    acc_t r;
    r.addr = a; r.we = we; r.chk_be = cb; r.be = be; r.chk_wd = cw; r.wd = wd;
    return r;
  endfunction

  function automatic rsp_t mk_rsp(input logic [31:0] d, input logic e);
    rsp_t r;
    r.rdata = d; r.err = e;
    return r;
  endfunction

  // Monitor: pops expectations whenever the DUT grants or responds.
  logic    prev_c_gnt, prev_h_gnt;
  acc_t    cur_acc;
  rsp_t    cur_rsp;
  req_id_t gid;

  always @(negedge clk) begin
    if (!rst) begin
      prev_c_gnt <= 1'b0;
      prev_h_gnt <= 1'b0;
    end else begin
      if (c_gnt || h_gnt) begin
        gid = c_gnt ? CORE : HOST;
        check("gnt_expected", {31'b0, order_q.size() != 0}, 32'd1);
        if (order_q.size() != 0) check("gnt_port", {31'b0, gid}, {31'b0, order_q.pop_front()});
        if (gid == CORE) begin
          check("c_acc_expected", {31'b0, c_acc_q.size() != 0}, 32'd1);
          if (c_acc_q.size() != 0) cur_acc = c_acc_q.pop_front();
        end else begin
          check("h_acc_expected", {31'b0, h_acc_q.size() != 0}, 32'd1);
          if (h_acc_q.size() != 0) cur_acc = h_acc_q.pop_front();
        end
        check("m_addr", {24'b0, m_addr}, {24'b0, cur_acc.addr});
        check("m_we", {31'b0, m_we}, {31'b0, cur_acc.we});
        if (cur_acc.chk_be) check("m_be", {28'b0, m_be}, {28'b0, cur_acc.be});
        if (cur_acc.chk_wd) check("m_wdata", m_wdata, cur_acc.wd);
      end else begin
        check("idle_we_be", {27'b0, m_we, m_be}, 32'd0);
      end

      if (c_rvalid) begin
        check("c_latency", {31'b0, prev_c_gnt}, 32'd1);
        check("c_rsp_expected", {31'b0, c_rsp_q.size() != 0}, 32'd1);
        if (c_rsp_q.size() != 0) begin
          cur_rsp = c_rsp_q.pop_front();
          check("c_rdata", c_rdata, cur_rsp.rdata);
          check("c_err", {31'b0, c_err}, {31'b0, cur_rsp.err});
        end
      end
      if (h_rvalid) begin
        check("h_latency", {31'b0, prev_h_gnt}, 32'd1);
        check("h_rsp_expected", {31'b0, h_rsp_q.size() != 0}, 32'd1);
        if (h_rsp_q.size() != 0) begin
          cur_rsp = h_rsp_q.pop_front();
          check("h_rdata", h_rdata, cur_rsp.rdata);
        end
      end
      prev_c_gnt <= c_gnt;
      prev_h_gnt <= h_gnt;
    end
  end

  // Issue one transaction; holds req until rvalid, then drops it.
  task automatic txn(input req_id_t id, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input acc_t acc, input rsp_t rsp, input bit push_order);
    logic seen;
    seen = 1'b0;
    if (push_order) order_q.push_back(id);
    if (id == CORE) begin
      c_acc_q.push_back(acc); c_rsp_q.push_back(rsp);
    end else begin
      h_acc_q.push_back(acc); h_rsp_q.push_back(rsp);
    end
    @(posedge clk); #1;
    if (id == CORE) begin
      c_req = 1'b1; c_we = we; c_funct3 = f3; c_addr = addr; c_wdata = wdata;
    end else begin
      h_req = 1'b1; h_we = we; h_addr = addr; h_wdata = wdata;
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = (id == CORE) ? c_rvalid : h_rvalid;
    end
    if (id == CORE) c_req = 1'b0;
    else            h_req = 1'b0;
    check("rvalid_seen", {31'b0, seen}, 32'd1);
  endtask

  task automatic core_ld(input logic [2:0] f3, input logic [31:0] addr, input logic [7:0] ma,
                         input logic [31:0] exp, input logic err, input bit po);
    txn(CORE, 1'b0, f3, addr, 32'h0, mk_acc(ma, 1'b0, err, 4'h0, 1'b0, 32'h0), mk_rsp(exp, err), po);
  endtask

  task automatic core_st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [7:0] ma, input logic [3:0] be, input logic [31:0] lane_wd,
                         input logic err);
    txn(CORE, 1'b1, f3, addr, wd, mk_acc(ma, !err, 1'b1, be, !err, lane_wd), mk_rsp(32'h0, err), 1'b1);
  endtask

  task automatic host_wr(input logic [31:0] addr, input logic [31:0] wd, input logic [7:0] ma);
    txn(HOST, 1'b1, F3_W, addr, wd, mk_acc(ma, 1'b1, 1'b1, 4'hF, 1'b1, wd), mk_rsp(32'h0, 1'b0), 1'b1);
  endtask

  task automatic host_rd(input logic [31:0] addr, input logic [7:0] ma, input logic [31:0] exp,
                         input bit po);
    txn(HOST, 1'b0, F3_W, addr, 32'h0, mk_acc(ma, 1'b0, 1'b1, 4'hF, 1'b0, 32'h0), mk_rsp(exp, 1'b0), po);
  endtask

  initial begin
    logic seen;
    rst = 1'b0;
    c_req = 0; c_we = 0; c_funct3 = '0; c_addr = '0; c_wdata = '0;
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;

    #12;
    check("reset_ctrl", {22'b0, c_gnt, c_rvalid, c_err, h_gnt, h_rvalid, m_we, m_be}, 32'd0);
    check("reset_c_rdata", c_rdata, 32'd0);
    check("reset_h_rdata", h_rdata, 32'd0);
    check("reset_m_addr", {24'b0, m_addr}, 32'd0);
    check("reset_m_wdata", m_wdata, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Preload through the host port.
    host_wr(32'h0,  32'h01020304, 8'd0);
    host_wr(32'h8,  32'hA5A55A5A, 8'd2);
    host_wr(32'h10, 32'hDEADBEEF, 8'd4);

    // Tie from reset: core first, then strict alternation.
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    order_q.push_back(CORE); order_q.push_back(HOST);
    order_q.push_back(CORE); order_q.push_back(HOST);
    fork
      begin
        core_ld(F3_W, 32'h10, 8'd4, 32'hDEADBEEF, 1'b0, 1'b0);
        core_ld(F3_W, 32'h08, 8'd2, 32'hA5A55A5A, 1'b0, 1'b0);
      end
      begin
        host_rd(32'h00, 8'd0, 32'h01020304, 1'b0);
        host_rd(32'h10, 8'd4, 32'hDEADBEEF, 1'b0);
      end
    join

    // Sub-word store and extended loads; word 4 becomes 0x80ADBEEF.
    core_st(F3_B,  32'h13, 32'h00000080, 8'd4, 4'b1000, 32'h80808080, 1'b0);
    core_ld(F3_B,  32'h13, 8'd4, 32'hFFFFFF80, 1'b0, 1'b1);
    core_ld(F3_BU, 32'h13, 8'd4, 32'h00000080, 1'b0, 1'b1);
    core_ld(F3_W,  32'h410, 8'd4, 32'h80ADBEEF, 1'b0, 1'b1);  // upper bits wrap

    // Host word access ignores addr[1:0].
    host_wr(32'h7, 32'h11223344, 8'd1);
    core_ld(F3_HU, 32'h6, 8'd1, 32'h00001122, 1'b0, 1'b1);
    core_ld(F3_H,  32'h4, 8'd1, 32'h00003344, 1'b0, 1'b1);
    core_ld(F3_B,  32'h5, 8'd1, 32'h00000033, 1'b0, 1'b1);

    // Upper halfword store, negative halfword load.
    core_st(F3_H,  32'h2A, 32'h1234ABCD, 8'd10, 4'b1100, 32'hABCDABCD, 1'b0);
    core_ld(F3_H,  32'h2A, 8'd10, 32'hFFFFABCD, 1'b0, 1'b1);
    core_ld(F3_HU, 32'h28, 8'd10, 32'h00000000, 1'b0, 1'b1);

    // Misaligned and illegal accesses.
    host_wr(32'h20, 32'h11223344, 8'd8);
    core_st(F3_W,  32'h22, 32'hCAFEF00D, 8'd8, 4'b0000, 32'h0, 1'b1);
    host_rd(32'h20, 8'd8, 32'h11223344, 1'b1);
    core_ld(F3_H,  32'h1, 8'd0, 32'h0, 1'b1, 1'b1);
    core_ld(3'b011, 32'h0, 8'd0, 32'h0, 1'b1, 1'b1);
    core_st(F3_BU, 32'h0, 32'hFFFFFFFF, 8'd0, 4'b0000, 32'h0, 1'b1);
    host_rd(32'h0, 8'd0, 32'h01020304, 1'b1);

    // Reset during the ACCESS cycle of a store.
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b1; c_funct3 = F3_B; c_addr = 32'h30; c_wdata = 32'h55;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = c_gnt;
    end
    check("rst_reached_access", {31'b0, seen}, 32'd1);
    check("rst_pre_we", {31'b0, m_we}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_async_we", {31'b0, m_we}, 32'd0);
    check("rst_async_gnt", {31'b0, c_gnt}, 32'd0);
    c_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_rvalid", {31'b0, c_rvalid}, 32'd0);
    end
    rst = 1'b1;

    // After reset the core wins the tie again; word 12 was never written.
    order_q.push_back(CORE); order_q.push_back(HOST);
    fork
      core_ld(F3_W, 32'h10, 8'd4, 32'h80ADBEEF, 1'b0, 1'b0);
      host_rd(32'h30, 8'd12, 32'h00000000, 1'b0);
    join

    repeat (3) @(posedge clk);
    check("queues_drained",
          order_q.size() + c_acc_q.size() + h_acc_q.size() + c_rsp_q.size() + h_rsp_q.size(),
          32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
